// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time instruction memory loader.
//
// Takes a byte stream over a valid/ready handshake. The first two bytes are a
// little-endian word count N; the next 4*N bytes are packed little-endian into
// 32-bit words and written to instruction memory at addresses 0..N-1. When the
// load completes, cpu_start is raised and held so the core can fetch from 0.
//
// Optional feature (macro IMEM_BOOT_CHECKSUM_EN): after the last word, one
// extra byte is accepted and compared against the XOR of all header and payload
// bytes. A mismatch flags err and returns to idle instead of starting the CPU.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   load_req     pulse, starts a load from idle/done, ignored while busy
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     byte accepted this cycle when in_valid is also high
//   imem_we      one-cycle write strobe per assembled word
//   imem_addr    word address of the write
//   imem_wdata   assembled word
//   cpu_start    high from load completion until the next load_req or rst
//   busy         high while a load is in progress
//   err          sticky error (oversize header or bad checksum)
module imem_boot_loader #(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       imem_we,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0]      imem_wdata,
  output logic                       cpu_start,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned Depth = 2 ** INST_ADDR_WIDTH;
  // One extra bit so a count equal to Depth is representable.
  localparam int unsigned CntW  = INST_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLoad,
`ifdef IMEM_BOOT_CHECKSUM_EN
    StChk,
`endif
    StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 byte_cnt_q;
  logic [CntW-1:0]            word_cnt_q;
  logic [CntW-1:0]            n_q;
  // Holds bytes 0..2 of the word in flight; byte 3 comes straight from in_data.
  logic [INST_WIDTH-9:0]      shift_q;
  logic                       we_q;
  logic [INST_ADDR_WIDTH-1:0] addr_q;
  logic [INST_WIDTH-1:0]      wdata_q;
  logic                       err_q;

  logic        xfer;
  logic        start_load;
  logic [15:0] hdr_n;
  logic        hdr_too_big;
  logic        load_done;

  assign xfer        = in_valid & in_ready;
  assign start_load  = load_req & ((state_q == StIdle) | (state_q == StDone));
  assign hdr_n       = {in_data, shift_q[7:0]};
  assign hdr_too_big = 32'(hdr_n) > Depth;
  // All words received; the final write is in flight this cycle.
  assign load_done   = (word_cnt_q == n_q);

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'd0;
    end else if (start_load) begin
      csum_q <= 8'd0;
    end else if (xfer && ((state_q == StHdr) || (state_q == StLoad))) begin
      csum_q <= csum_q ^ in_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (load_req) state_d = StHdr;
      end
      StHdr: begin
        if (xfer && byte_cnt_q[0]) begin
          if (hdr_n == 16'd0) begin
            state_d = StDone;
          end else if (hdr_too_big) begin
            state_d = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (load_done) state_d = StChk;
`else
        if (load_done) state_d = StDone;
`endif
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      StChk: begin
        if (xfer) state_d = (in_data == csum_q) ? StDone : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    cpu_start = 1'b0;
    case (state_q)
      StHdr: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StLoad: begin
        // Stop accepting once the last word is in; no stray byte is swallowed.
        in_ready = ~load_done;
        busy     = 1'b1;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      StChk: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      StDone: cpu_start = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header capture, word packing and memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (load_req) begin
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
          end
        end
        StHdr: begin
          if (xfer) begin
            if (byte_cnt_q[0]) begin
              byte_cnt_q <= 2'd0;
              n_q        <= hdr_n[CntW-1:0];
              if (hdr_too_big) err_q <= 1'b1;
            end else begin
              shift_q[7:0] <= in_data;
              byte_cnt_q   <= 2'd1;
            end
          end
        end
        StLoad: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: shift_q[7:0]   <= in_data;
              2'd1: shift_q[15:8]  <= in_data;
              2'd2: shift_q[23:16] <= in_data;
              default: begin
                we_q       <= 1'b1;
                addr_q     <= word_cnt_q[INST_ADDR_WIDTH-1:0];
                wdata_q    <= {in_data, shift_q};
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            endcase
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        StChk: begin
          if (xfer && (in_data != csum_q)) err_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each imem_we pulse.
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       imem_we;
  logic [6:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_start;
  logic       busy;
  logic       err;

  typedef logic [7:0]  bytes_t[$];
  typedef logic [31:0] words_t[$];
  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   asserts  = 0;
  int   fails    = 0;
  int   neg_cnt  = 0;
  int   wr_count = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .INST_WIDTH      (32),
    .INST_ADDR_WIDTH (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard, including timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (imem_we === 1'b1) begin
        wr_count++;
        if (sb.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                   imem_addr, imem_wdata);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(e.addr));
          check("wr_data", imem_wdata, e.data);
          check("wr_latency", 32'(neg_cnt), 32'(e.due));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int xfer_neg);
    int t;
    xfer_neg = -1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("xfer_ready", 32'(in_ready), 32'd1);
    if (in_ready === 1'b1) begin
      @(posedge clk);
      xfer_neg = neg_cnt;
      #1;
    end
    in_valid = 1'b0;
  endtask

  // base: stream position of bs[0] (header bytes are positions 0 and 1).
  task automatic stream(input bytes_t bs, input words_t ws, input int max_gap, input int base);
    int xn;
    int p;
    int w;
    for (int i = 0; i < bs.size(); i++) begin
      send_byte(bs[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, xn);
      p = i + base;
      if (p >= 2 && ((p - 2) % 4) == 3) begin
        w = (p - 2) / 4;
        if (w < ws.size()) sb.push_back('{addr: 7'(w), data: ws[w], due: xn + 1});
      end
    end
  endtask

  task automatic pulse_load();
    @(posedge clk);
    #1 load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Appends the XOR checksum byte when the checksum build is selected.
  function automatic bytes_t frame(input bytes_t b);
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
`endif
    return b;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t main_bytes;
    words_t main_words;
    int     wr0;

    main_bytes = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    main_words = '{32'h0000_0013, 32'h0010_0093};

    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    settle(2);
    check("rst_in_ready",   32'(in_ready),  32'd0);
    check("rst_imem_we",    32'(imem_we),   32'd0);
    check("rst_imem_addr",  32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata,     32'd0);
    check("rst_cpu_start",  32'(cpu_start), 32'd0);
    check("rst_busy",       32'(busy),      32'd0);
    check("rst_err",        32'(err),       32'd0);
    rst = 1'b0;

    // Basic two-word load at full rate.
    @(posedge clk);
    #1 load_req = 1'b1;
    check("ready_low_on_load_req", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 load_req = 1'b0;
    check("hdr_busy",  32'(busy),     32'd1);
    check("hdr_ready", 32'(in_ready), 32'd1);
    wr0 = wr_count;
    stream(frame(main_bytes), main_words, 0, 0);
    settle(3);
    check("t1_cpu_start", 32'(cpu_start),       32'd1);
    check("t1_busy",      32'(busy),            32'd0);
    check("t1_err",       32'(err),             32'd0);
    check("t1_ready",     32'(in_ready),        32'd0);
    check("t1_writes",    32'(wr_count - wr0),  32'd2);
    check("t1_pending",   32'(sb.size()),       32'd0);

    // Same stream with random valid gaps.
    pulse_load();
    check("t2_start_cleared", 32'(cpu_start), 32'd0);
    wr0 = wr_count;
    stream(frame(main_bytes), main_words, 5, 0);
    settle(3);
    check("t2_cpu_start", 32'(cpu_start),      32'd1);
    check("t2_writes",    32'(wr_count - wr0), 32'd2);
    check("t2_pending",   32'(sb.size()),      32'd0);

    // load_req mid-load is ignored.
    pulse_load();
    wr0 = wr_count;
    stream('{8'h01, 8'h00, 8'hAA, 8'hBB}, '{32'hDDCC_BBAA}, 0, 0);
    pulse_load();
    check("t3_busy_kept", 32'(busy), 32'd1);
`ifdef IMEM_BOOT_CHECKSUM_EN
    stream('{8'hCC, 8'hDD, 8'h01}, '{32'hDDCC_BBAA}, 0, 4);
`else
    stream('{8'hCC, 8'hDD}, '{32'hDDCC_BBAA}, 0, 4);
`endif
    settle(3);
    check("t3_cpu_start", 32'(cpu_start),      32'd1);
    check("t3_err",       32'(err),            32'd0);
    check("t3_writes",    32'(wr_count - wr0), 32'd1);

    // Oversize header N=129.
    pulse_load();
    wr0 = wr_count;
    stream('{8'h81, 8'h00}, '{}, 0, 0);
    check("t4_err",       32'(err),       32'd1);
    check("t4_busy",      32'(busy),      32'd0);
    check("t4_ready",     32'(in_ready),  32'd0);
    settle(3);
    check("t4_cpu_start", 32'(cpu_start),      32'd0);
    check("t4_writes",    32'(wr_count - wr0), 32'd0);
    pulse_load();
    check("t4_err_cleared", 32'(err),  32'd0);
    check("t4_busy_again",  32'(busy), 32'd1);

    // Empty load N=0 (loader already in header phase).
    stream('{8'h00, 8'h00}, '{}, 0, 0);
    settle(2);
    check("t5_cpu_start", 32'(cpu_start),      32'd1);
    check("t5_busy",      32'(busy),           32'd0);
    check("t5_ready",     32'(in_ready),       32'd0);
    check("t5_writes",    32'(wr_count - wr0), 32'd0);

    // Reset after six payload bytes of a three-word load.
    pulse_load();
    wr0 = wr_count;
    stream('{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, '{32'h0403_0201}, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_ready",  32'(in_ready),  32'd0);
    check("t6_busy",   32'(busy),      32'd0);
    check("t6_we",     32'(imem_we),   32'd0);
    check("t6_addr",   32'(imem_addr), 32'd0);
    check("t6_wdata",  imem_wdata,     32'd0);
    check("t6_start",  32'(cpu_start), 32'd0);
    check("t6_err",    32'(err),       32'd0);
    check("t6_writes", 32'(wr_count - wr0), 32'd1);
    check("t6_pending", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pulse_load();
    wr0 = wr_count;
    stream(frame(main_bytes), main_words, 0, 0);
    settle(3);
    check("t7_cpu_start", 32'(cpu_start),      32'd1);
    check("t7_writes",    32'(wr_count - wr0), 32'd2);

`ifdef IMEM_BOOT_CHECKSUM_EN
    pulse_load();
    stream('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23}, '{32'hDEAD_BEEF}, 0, 0);
    settle(3);
    check("t8_cpu_start", 32'(cpu_start), 32'd1);
    check("t8_err",       32'(err),       32'd0);
    pulse_load();
    stream('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h24}, '{32'hDEAD_BEEF}, 0, 0);
    settle(3);
    check("t9_err",       32'(err),        32'd1);
    check("t9_cpu_start", 32'(cpu_start),  32'd0);
    check("t9_busy",      32'(busy),       32'd0);
    check("t9_pending",   32'(sb.size()),  32'd0);
`endif

    settle(2);
    check("final_pending", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
